// File: rtl/primo_16b_if.sv
// Operand/flag bundle for the 16-bit primality detector.
// The master presents N each clock; the slave returns the registered flag F.
interface primo_16b_if;
  logic [15:0] N;
  logic        F;

  modport master (output N, input F);
  modport slave  (input N, output F);
endinterface

// File: rtl/primo_16b.sv
// Registered 16-bit primality detector.
// N is tested combinationally by trial division against every prime up to 251.
// The verdict is captured in one flip-flop, so F is clean and clock-aligned.
// Since 251^2 <= 65535 < 257^2, any composite 16-bit value has a factor in this set.
module primo_16b (
  input  logic        clk,
  input  logic        rst_n,
  primo_16b_if.slave  bus
);

  localparam int NUM_PRIMES = 54;

  localparam logic [7:0] PRIMES [NUM_PRIMES] = '{
    8'd2,   8'd3,   8'd5,   8'd7,   8'd11,  8'd13,  8'd17,  8'd19,  8'd23,  8'd29,
    8'd31,  8'd37,  8'd41,  8'd43,  8'd47,  8'd53,  8'd59,  8'd61,  8'd67,  8'd71,
    8'd73,  8'd79,  8'd83,  8'd89,  8'd97,  8'd101, 8'd103, 8'd107, 8'd109, 8'd113,
    8'd127, 8'd131, 8'd137, 8'd139, 8'd149, 8'd151, 8'd157, 8'd163, 8'd167, 8'd173,
    8'd179, 8'd181, 8'd191, 8'd193, 8'd197, 8'd199, 8'd211, 8'd223, 8'd227, 8'd229,
    8'd233, 8'd239, 8'd241, 8'd251
  };

  // A value is prime when it is at least 2 and no listed prime divides it,
  // except the value itself (so 2, 3, ..., 251 are kept as prime).
  function automatic logic is_prime(input logic [15:0] n);
    logic        ok;
    logic [15:0] p;
    ok = (n >= 16'd2);
    for (int i = 0; i < NUM_PRIMES; i++) begin
      p = {8'd0, PRIMES[i]};
      if ((n % p) == 16'd0 && n != p) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

  logic prime_p0;
  logic f_p1;

  // Stage 0: combinational divisibility verdict for the current N.
  always_comb begin
    prime_p0 = 1'b0;
    prime_p0 = is_prime(bus.N);
  end

  // Stage 1: single output register; reset clears it immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_p1 <= 1'b0;
    end else begin
      f_p1 <= prime_p0;
    end
  end

  assign bus.F = f_p1;

endmodule

// File: tb/tb_primo_16b.sv
// Directed and exhaustive bench for the registered 16-bit primality detector.
module tb_primo_16b;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  primo_16b_if bus ();

  primo_16b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain trial division by every integer up to sqrt(n).
  function automatic logic model_prime(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++) begin
      if (n % d == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Apply one value, clock it in, and check F one edge later.
  task automatic apply_check(input logic [15:0] n, input logic exp, input string name);
    bus.N = n;
    @(posedge clk);
    #1;
    total++;
    if (bus.F !== exp) begin
      bad++;
      $display("FAIL %s N=%0d: F=%b expected %b", name, n, bus.F, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.N = 16'd2;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (bus.F !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: F=%b expected 0", bus.F);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.F !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: F=%b expected 1", bus.F);
    end
    // Pull reset low between edges; F must clear without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.F !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: F=%b expected 0", bus.F);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_small();
    logic [15:0] vals [8] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd9, 16'd49};
    logic        exps [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      apply_check(vals[i], exps[i], "small");
    end
  endtask

  task automatic test_boundary();
    apply_check(16'd251,   1'b1, "bound_251");
    apply_check(16'd257,   1'b1, "bound_257");
    apply_check(16'd63001, 1'b0, "bound_251sq");
    apply_check(16'd32749, 1'b1, "bound_32749");
    apply_check(16'd121,   1'b0, "bound_11sq");
    apply_check(16'd2,     1'b1, "bound_2");
  endtask

  task automatic test_top();
    apply_check(16'd65521, 1'b1, "top_65521");
    apply_check(16'd65535, 1'b0, "top_65535");
    apply_check(16'd65534, 1'b0, "top_65534");
  endtask

  task automatic test_sweep();
    int   ones;
    logic exp;
    ones = 0;
    for (int v = 0; v < 65536; v++) begin
      bus.N = 16'(v);
      exp = model_prime(v);
      @(posedge clk);
      #1;
      total++;
      if (bus.F !== exp) begin
        bad++;
        $display("FAIL sweep N=%0d: F=%b expected %b", v, bus.F, exp);
      end
      if (bus.F === 1'b1) ones++;
    end
    total++;
    if (ones !== 6542) begin
      bad++;
      $display("FAIL sweep_count: primes=%0d expected 6542", ones);
    end
  endtask

  // Alternate 7/8; before each edge F must still show the previous verdict.
  task automatic test_back_to_back();
    logic prev;
    logic exp;
    bus.N = 16'd8;
    @(posedge clk);
    #1;
    prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.N = (i % 2 == 0) ? 16'd7 : 16'd8;
      exp   = (i % 2 == 0);
      #1;
      total++;
      if (bus.F !== prev) begin
        bad++;
        $display("FAIL lat_hold i=%0d: F=%b expected %b", i, bus.F, prev);
      end
      @(posedge clk);
      #1;
      total++;
      if (bus.F !== exp) begin
        bad++;
        $display("FAIL lat_update i=%0d: F=%b expected %b", i, bus.F, exp);
      end
      prev = exp;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.N = 16'd0;
    test_reset();
    test_small();
    test_boundary();
    test_top();
    test_back_to_back();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
